// File: rtl/control_unit_pkg.sv
// control_unit_pkg: shared definitions for the instruction sequencer.
//   - control-line indices into the control vector (index 0 is the MSB of
//     the [0:NCTRL-1] vector)
//   - FSM state and opcode encodings
package control_unit_pkg;

  // Control-line indices.
  localparam int INIT_PC  = 0;
  localparam int ABUS_PC  = 1;
  localparam int ABUS_R0  = 2;
  localparam int IR_RBUS  = 3;
  localparam int R0_RBUS  = 4;
  localparam int INC_PC   = 5;
  localparam int ACC_RBUS = 6;
  localparam int ADD_OP   = 7;
  localparam int ACC_ALU  = 8;
  localparam int WBUS_ACC = 9;
  localparam int PC_R0    = 10;

  localparam int MAX_CONTROL_LINES = 11;

  typedef enum logic [3:0] {
    S_RESET,
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_RD_OP,
    S_WR_OP,
    S_ALU,
    S_BRANCH,
    S_HALTED
  } state_e;

  typedef enum logic [3:0] {
    OP_HLT = 4'h0,
    OP_LDA = 4'h1,
    OP_STA = 4'h2,
    OP_ADD = 4'h3,
    OP_JMP = 4'h4,
    OP_JZ  = 4'h5
  } opcode_e;

endpackage

// File: rtl/control_unit.sv
// control_unit: fetch / decode / execute sequencer for data_path.
// Ports:
//   clk, rst_n  - clock (rising edge), asynchronous active-low reset
//   run         - start next instruction; sampled only in IDLE
//   IR          - opcode from the datapath IR register
//   Z           - zero flag from the datapath
//   mem_ack     - memory completion (may arrive in the first request cycle)
//   control     - datapath control lines, indices from control_unit_pkg
//   mem_req     - memory request, held until mem_ack
//   mem_we      - write qualifier, valid while mem_req is high
//   halted      - high while in HALTED
//   illegal     - one-cycle pulse when DECODE sees an undefined opcode
// NCTRL must be at least MAX_CONTROL_LINES.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int NCTRL = MAX_CONTROL_LINES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [3:0]       IR,
  input  logic             Z,
  input  logic             mem_ack,
  output logic [0:NCTRL-1] control,
  output logic             mem_req,
  output logic             mem_we,
  output logic             halted,
  output logic             illegal
);

  state_e           state_q, state_d;
  logic [0:NCTRL-1] ctrl_d;
  logic             req_d, we_d, halt_d, ill_d;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    ctrl_d  = '0;
    req_d   = 1'b0;
    we_d    = 1'b0;
    halt_d  = 1'b0;
    ill_d   = 1'b0;

    case (state_q)
      S_RESET: begin
        ctrl_d[INIT_PC] = 1'b1;
        state_d         = S_IDLE;
      end

      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end

      S_FETCH: begin
        // Capture strobes are qualified by mem_ack so the datapath only
        // loads IR/R0 and bumps PC on the completing edge.
        ctrl_d[ABUS_PC] = 1'b1;
        req_d           = 1'b1;
        if (mem_ack) begin
          ctrl_d[IR_RBUS] = 1'b1;
          ctrl_d[R0_RBUS] = 1'b1;
          ctrl_d[INC_PC]  = 1'b1;
          state_d         = S_DECODE;
        end
      end

      S_DECODE: begin
        case (IR)
          OP_LDA, OP_ADD: state_d = S_RD_OP;
          OP_STA:         state_d = S_WR_OP;
          OP_JMP, OP_JZ:  state_d = S_BRANCH;
          OP_HLT:         state_d = S_HALTED;
          default: begin
            ill_d   = 1'b1;
            state_d = S_IDLE;
          end
        endcase
      end

      S_RD_OP: begin
        ctrl_d[ABUS_R0] = 1'b1;
        req_d           = 1'b1;
        if (mem_ack) begin
          if (IR == OP_ADD) begin
            ctrl_d[R0_RBUS] = 1'b1;
            state_d         = S_ALU;
          end else begin
            ctrl_d[ACC_RBUS] = 1'b1;
            state_d          = S_IDLE;
          end
        end
      end

      S_ALU: begin
        ctrl_d[ADD_OP]  = 1'b1;
        ctrl_d[ACC_ALU] = 1'b1;
        state_d         = S_IDLE;
      end

      S_WR_OP: begin
        ctrl_d[ABUS_R0]  = 1'b1;
        ctrl_d[WBUS_ACC] = 1'b1;
        req_d            = 1'b1;
        we_d             = 1'b1;
        if (mem_ack) state_d = S_IDLE;
      end

      S_BRANCH: begin
        // Z is stable here: nothing between the last ALU cycle and this
        // one writes the flag.
        if (IR == OP_JMP || (IR == OP_JZ && Z)) ctrl_d[PC_R0] = 1'b1;
        state_d = S_IDLE;
      end

      S_HALTED: begin
        halt_d = 1'b1;
      end

      default: state_d = S_RESET;
    endcase
  end

  // NOTE: outputs are gated by rst_n so they clear the instant reset is
  // asserted, dropping any outstanding request without waiting for a clock.
  assign control = rst_n ? ctrl_d : '0;
  assign mem_req = rst_n & req_d;
  assign mem_we  = rst_n & we_d;
  assign halted  = rst_n & halt_d;
  assign illegal = rst_n & ill_d;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed, table-driven bench for control_unit. The bench
// plays the datapath and memory: it drives IR, Z and mem_ack cycle by cycle
// and compares every output against hand-computed values.
module tb_control_unit;
  import control_unit_pkg::*;

  localparam int NC = MAX_CONTROL_LINES;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run;
  logic [3:0]    ir;
  logic          z;
  logic          mem_ack;
  logic [0:NC-1] control;
  logic          mem_req;
  logic          mem_we;
  logic          halted;
  logic          illegal;

  int checks = 0;
  int errors = 0;

  control_unit #(.NCTRL(NC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .IR      (ir),
    .Z       (z),
    .mem_ack (mem_ack),
    .control (control),
    .mem_req (mem_req),
    .mem_we  (mem_we),
    .halted  (halted),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          run;
    logic [3:0]    ir;
    logic          z;
    logic          ack;
    logic [0:NC-1] ctrl;
    logic          req;
    logic          we;
    logic          halt;
    logic          ill;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [0:NC-1] cm(input int idx);
    logic [0:NC-1] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic vec_t mk(input logic r, input logic [3:0] i, input logic zz,
                              input logic a, input logic [0:NC-1] c,
                              input logic rq, input logic w, input logic h,
                              input logic il);
    vec_t v;
    v.run = r; v.ir = i; v.z = zz; v.ack = a; v.ctrl = c;
    v.req = rq; v.we = w; v.halt = h; v.ill = il;
    return v;
  endfunction

  function automatic logic [31:0] obs();
    return {17'b0, control, mem_req, mem_we, halted, illegal};
  endfunction

  function automatic logic [31:0] expv(input logic [0:NC-1] c, input logic rq,
                                       input logic w, input logic h, input logic il);
    return {17'b0, c, rq, w, h, il};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (ctrl,req,we,halted,illegal)", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, compare on the
  // falling edge, then advance to just after the next rising edge.
  task automatic step(input string name, input vec_t v);
    run = v.run; ir = v.ir; z = v.z; mem_ack = v.ack;
    @(negedge clk);
    check(name, obs(), expv(v.ctrl, v.req, v.we, v.halt, v.ill));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [0:NC-1] f_ack, zero;
    zero  = '0;
    f_ack = cm(ABUS_PC) | cm(IR_RBUS) | cm(R0_RBUS) | cm(INC_PC);

    //             run  ir    z  ack  ctrl                         req we h  il
    tbl.push_back(mk(0, 4'h0, 0, 0, cm(INIT_PC),                  0, 0, 0, 0)); // RESET
    tbl.push_back(mk(0, 4'h0, 0, 0, zero,                         0, 0, 0, 0)); // IDLE
    tbl.push_back(mk(1, 4'h0, 0, 0, zero,                         0, 0, 0, 0)); // IDLE, run
    tbl.push_back(mk(1, 4'h1, 0, 1, f_ack,                        1, 0, 0, 0)); // FETCH LDA
    tbl.push_back(mk(0, 4'h1, 0, 0, zero,                         0, 0, 0, 0)); // DECODE, run drops
    tbl.push_back(mk(0, 4'h1, 0, 1, cm(ABUS_R0) | cm(ACC_RBUS),   1, 0, 0, 0)); // RD_OP LDA
    tbl.push_back(mk(1, 4'h1, 0, 0, zero,                         0, 0, 0, 0)); // IDLE
    tbl.push_back(mk(1, 4'h3, 0, 1, f_ack,                        1, 0, 0, 0)); // FETCH ADD
    tbl.push_back(mk(1, 4'h3, 0, 0, zero,                         0, 0, 0, 0)); // DECODE
    tbl.push_back(mk(1, 4'h3, 0, 1, cm(ABUS_R0) | cm(R0_RBUS),    1, 0, 0, 0)); // RD_OP ADD
    tbl.push_back(mk(1, 4'h3, 0, 0, cm(ADD_OP) | cm(ACC_ALU),     0, 0, 0, 0)); // ALU
    tbl.push_back(mk(1, 4'h3, 0, 0, zero,                         0, 0, 0, 0)); // IDLE
    tbl.push_back(mk(1, 4'h5, 1, 1, f_ack,                        1, 0, 0, 0)); // FETCH JZ
    tbl.push_back(mk(1, 4'h5, 1, 0, zero,                         0, 0, 0, 0)); // DECODE
    tbl.push_back(mk(1, 4'h5, 1, 0, cm(PC_R0),                    0, 0, 0, 0)); // BRANCH taken
    tbl.push_back(mk(1, 4'h5, 0, 0, zero,                         0, 0, 0, 0)); // IDLE
    tbl.push_back(mk(1, 4'h5, 0, 1, f_ack,                        1, 0, 0, 0)); // FETCH JZ
    tbl.push_back(mk(1, 4'h5, 0, 0, zero,                         0, 0, 0, 0)); // DECODE
    tbl.push_back(mk(1, 4'h5, 0, 0, zero,                         0, 0, 0, 0)); // BRANCH not taken
    tbl.push_back(mk(1, 4'h4, 0, 0, zero,                         0, 0, 0, 0)); // IDLE
    tbl.push_back(mk(1, 4'h4, 0, 1, f_ack,                        1, 0, 0, 0)); // FETCH JMP
    tbl.push_back(mk(1, 4'h4, 0, 0, zero,                         0, 0, 0, 0)); // DECODE
    tbl.push_back(mk(1, 4'h4, 0, 0, cm(PC_R0),                    0, 0, 0, 0)); // BRANCH JMP, Z=0
    tbl.push_back(mk(1, 4'hA, 0, 0, zero,                         0, 0, 0, 0)); // IDLE
    tbl.push_back(mk(1, 4'hA, 0, 1, f_ack,                        1, 0, 0, 0)); // FETCH 0xA
    tbl.push_back(mk(1, 4'hA, 0, 0, zero,                         0, 0, 0, 1)); // DECODE illegal
    tbl.push_back(mk(1, 4'hA, 0, 0, zero,                         0, 0, 0, 0)); // IDLE, pulse gone
    tbl.push_back(mk(1, 4'h2, 0, 0, cm(ABUS_PC),                  1, 0, 0, 0)); // FETCH wait
    tbl.push_back(mk(1, 4'h2, 0, 1, f_ack,                        1, 0, 0, 0)); // FETCH ack
    tbl.push_back(mk(0, 4'h2, 0, 0, zero,                         0, 0, 0, 0)); // DECODE STA
    tbl.push_back(mk(0, 4'h2, 0, 1, cm(ABUS_R0) | cm(WBUS_ACC),   1, 1, 0, 0)); // WR_OP ack
    tbl.push_back(mk(0, 4'h2, 0, 1, zero,                         0, 0, 0, 0)); // IDLE, stray ack
    tbl.push_back(mk(0, 4'h2, 0, 1, zero,                         0, 0, 0, 0)); // IDLE, no run

    // Reset held: outputs all zero even with run and mem_ack high.
    rst_n = 1'b0; run = 1'b1; ir = 4'h1; z = 1'b0; mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hold", obs(), expv(zero, 0, 0, 0, 0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step($sformatf("row%0d", i), tbl[i]);

    // STA with three wait cycles: request, write and address lines steady.
    step("sta_idle",   mk(1, 4'h2, 0, 0, zero,  0, 0, 0, 0));
    step("sta_fetch",  mk(0, 4'h2, 0, 1, f_ack, 1, 0, 0, 0));
    step("sta_decode", mk(0, 4'h2, 0, 0, zero,  0, 0, 0, 0));
    for (int w = 0; w < 3; w++)
      step($sformatf("sta_wait%0d", w), mk(0, 4'h2, 0, 0, cm(ABUS_R0) | cm(WBUS_ACC), 1, 1, 0, 0));
    step("sta_ack",    mk(0, 4'h2, 0, 1, cm(ABUS_R0) | cm(WBUS_ACC), 1, 1, 0, 0));
    step("sta_drop",   mk(0, 4'h2, 0, 0, zero,  0, 0, 0, 0));

    // HLT: halted stays up, no request regardless of run or mem_ack.
    step("hlt_idle",   mk(1, 4'h0, 0, 0, zero,  0, 0, 0, 0));
    step("hlt_fetch",  mk(1, 4'h0, 0, 1, f_ack, 1, 0, 0, 0));
    step("hlt_decode", mk(1, 4'h0, 0, 0, zero,  0, 0, 0, 0));
    for (int h = 0; h < 4; h++)
      step($sformatf("halted%0d", h), mk(1, 4'h1, 0, h[0], zero, 0, 0, 1, 0));

    // Reset mid-read: request drops combinationally, INIT_PC on release.
    rst_n = 1'b0;
    #1 check("reset_from_halt", obs(), expv(zero, 0, 0, 0, 0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("rr_reset",  mk(0, 4'h1, 0, 0, cm(INIT_PC), 0, 0, 0, 0));
    step("rr_idle",   mk(1, 4'h1, 0, 0, zero,        0, 0, 0, 0));
    step("rr_fetch",  mk(1, 4'h1, 0, 1, f_ack,       1, 0, 0, 0));
    step("rr_decode", mk(1, 4'h1, 0, 0, zero,        0, 0, 0, 0));
    run = 1'b1; ir = 4'h1; mem_ack = 1'b0;
    #2 check("rr_wait", obs(), expv(cm(ABUS_R0), 1, 0, 0, 0));
    rst_n = 1'b0;
    #1 check("rr_abandon", obs(), expv(zero, 0, 0, 0, 0));
    @(posedge clk);
    #1 check("rr_held", obs(), expv(zero, 0, 0, 0, 0));
    rst_n = 1'b1;
    step("rr_init",   mk(0, 4'h1, 0, 0, cm(INIT_PC), 0, 0, 0, 0));
    step("rr_idle2",  mk(0, 4'h1, 0, 0, zero,        0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
